// File: rtl/fetch_queue_unit.sv
// Instruction fetch queue: issues sequential fetch requests under a
// credit limit and buffers in-order memory responses for decode.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   jump_flag_i, jump_addr_i   redirect pulse and its target
//   request_o, req_ready_i,
//   req_addr_o                 fetch request handshake and address
//   data_ok_i, inst_fetch_i    in-order memory response
//   valid_o, ready_i, inst_o,
//   inst_addr_o                decode handshake and head entry
//   count_o                    number of buffered instructions
module fetch_queue_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      jump_flag_i,
    input  logic [ADDR_WIDTH-1:0]     jump_addr_i,
    output logic                      request_o,
    input  logic                      req_ready_i,
    output logic [ADDR_WIDTH-1:0]     req_addr_o,
    input  logic                      data_ok_i,
    input  logic [DATA_WIDTH-1:0]     inst_fetch_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [DATA_WIDTH-1:0]     inst_o,
    output logic [ADDR_WIDTH-1:0]     inst_addr_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc;

    logic [ADDR_WIDTH-1:0] aq_mem [DEPTH];
    logic [PW-1:0]         aq_wr;
    logic [PW-1:0]         aq_rd;

    logic [DATA_WIDTH-1:0] inst_mem  [DEPTH];
    logic [ADDR_WIDTH-1:0] iaddr_mem [DEPTH];
    logic [PW-1:0]         fq_wr;
    logic [PW-1:0]         fq_rd;

    logic [CW-1:0]         count;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         discard;

    logic [DATA_WIDTH-1:0] hold_inst;
    logic [ADDR_WIDTH-1:0] hold_addr;

    logic accept;
    logic resp;
    logic push;
    logic pop;

    // Buffered plus outstanding entries never exceed DEPTH, so a
    // response always has a free FIFO slot.
    assign request_o  = !reset && !jump_flag_i &&
                        (({1'b0, inflight} + {1'b0, count}) < DEPTH_EXT);
    assign req_addr_o = pc;
    assign accept     = request_o && req_ready_i;

    // Responses with nothing outstanding are ignored.
    assign resp = data_ok_i && (inflight != '0);
    assign push = resp && !jump_flag_i && (discard == '0);

    assign valid_o = !reset && (count != '0) && !jump_flag_i;
    assign pop     = valid_o && ready_i;

    // Head shown from storage while valid, otherwise the last shown pair.
    assign inst_o      = reset   ? '0 :
                         valid_o ? inst_mem[fq_rd] : hold_inst;
    assign inst_addr_o = reset   ? '0 :
                         valid_o ? iaddr_mem[fq_rd] : hold_addr;
    assign count_o     = reset ? '0 : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            aq_wr     <= '0;
            aq_rd     <= '0;
            fq_wr     <= '0;
            fq_rd     <= '0;
            count     <= '0;
            inflight  <= '0;
            discard   <= '0;
            hold_inst <= '0;
            hold_addr <= '0;
        end else begin
            if (jump_flag_i) begin
                pc <= jump_addr_i;
            end else if (accept) begin
                pc <= pc + ADDR_WIDTH'(4);
            end

            if (accept) begin
                aq_mem[aq_wr] <= pc;
                aq_wr         <= aq_wr + PW'(1);
            end
            if (resp) begin
                aq_rd <= aq_rd + PW'(1);
            end

            inflight <= inflight + CW'(accept) - CW'(resp);

            // On a redirect everything still outstanding after this
            // cycle's response is stale, recomputed from scratch.
            if (jump_flag_i) begin
                discard <= inflight - CW'(resp);
            end else if (resp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end

            if (push) begin
                inst_mem[fq_wr]  <= inst_fetch_i;
                iaddr_mem[fq_wr] <= aq_mem[aq_rd];
            end

            if (jump_flag_i) begin
                fq_wr <= '0;
                fq_rd <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    fq_wr <= fq_wr + PW'(1);
                end
                if (pop) begin
                    fq_rd <= fq_rd + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end

            if (valid_o) begin
                hold_inst <= inst_o;
                hold_addr <= inst_addr_o;
            end
        end
    end

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter ADDR_WIDTH, default 32, fetch address width.
REQ-003 Parameter DEPTH, default 4, buffer entries and maximum in-flight requests; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-005 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port jump_flag_i  in  1  redirect request, single-cycle pulse.
REQ-008 Port jump_addr_i  in  ADDR_WIDTH  redirect target.
REQ-009 Port request_o  out  1  memory fetch request valid.
REQ-010 Port req_ready_i  in  1  memory accepts request this cycle.
REQ-011 Port req_addr_o  out  ADDR_WIDTH  fetch address (current PC).
REQ-012 Port data_ok_i  in  1  in-order response valid from memory.
REQ-013 Port inst_fetch_i  in  DATA_WIDTH  response instruction.
REQ-014 Port valid_o  out  1  instruction available to decode.
REQ-015 Port ready_i  in  1  decode accepts instruction.
REQ-016 Port inst_o  out  DATA_WIDTH  head instruction.
REQ-017 Port inst_addr_o  out  ADDR_WIDTH  address of head instruction.
REQ-018 Port count_o  out  clog2(DEPTH)+1  buffered-entry count.

Function
REQ-019 Internal state: PC register, address queue (DEPTH), inst/addr FIFO (DEPTH), inflight counter, discard counter.
REQ-020 request_o SHALL be 1 iff inflight + count_o < DEPTH and jump_flag_i = 0; req_addr_o = PC.
REQ-021 Accept (request_o & req_ready_i): PC <= PC + 4, PC pushed into address queue, inflight increments.
REQ-022 request_o and req_addr_o SHALL remain stable while request_o = 1 and req_ready_i = 0, absent jump.
REQ-023 Response (data_ok_i): inflight decrements, oldest address popped; if discard > 0, response dropped and discard decrements, else {address, inst_fetch_i} pushed into FIFO.
REQ-024 Response-to-valid_o latency SHALL be exactly 1 cycle (no bypass).
REQ-025 valid_o = FIFO not empty & ~jump_flag_i; inst_o/inst_addr_o show FIFO head combinationally from storage.
REQ-026 Pop on valid_o & ready_i; simultaneous push and pop keeps count_o unchanged.
REQ-027 Credit rule (REQ-020) guarantees no push when full; overflow SHALL never occur.
REQ-028 data_ok_i with inflight = 0 is a protocol violation and SHALL be ignored (no state change).
REQ-029 Jump cycle: PC <= jump_addr_i; FIFO flushed (count_o = 0 next cycle); no request issued; no pop.
REQ-030 Jump cycle: discard <= inflight - data_ok_i, so every outstanding response, including one arriving in the jump cycle, is dropped.
REQ-031 Jump while discard > 0 SHALL recompute discard per REQ-030 (no double counting).
REQ-032 FIFO and address-queue pointers SHALL wrap modulo DEPTH without bubbles.
REQ-033 inst_o/inst_addr_o SHALL hold last values when valid_o = 0 (no X).

Reset
REQ-034 reset = 1 at an edge: PC = RESET_PC, FIFO empty, inflight = 0, discard = 0.
REQ-035 During and after reset: valid_o = 0, count_o = 0, inst_o = 0, inst_addr_o = 0.
REQ-036 Reset mid-operation SHALL abandon all in-flight requests; first request_o occurs on the first cycle after reset deasserts.

Verification
REQ-037 Reset, req_ready_i = 1, memory latency 1 -> requests 0x80000000, 0x80000004, ...; inst_o/inst_addr_o pairs in order; valid_o 1 cycle after each data_ok_i.
REQ-038 ready_i = 0, DEPTH = 4 -> exactly 4 requests accepted, request_o = 0, count_o = 4; one pop -> request_o = 1 next cycle.
REQ-039 3 requests in flight, jump to 0x100 -> 3 responses dropped; next valid_o shows inst_addr_o = 0x100.
REQ-040 Jump in same cycle as data_ok_i with inflight = 2 -> discard = 1; that response and next dropped.
REQ-041 Continuous push/pop over 3*DEPTH entries -> pointer wrap, count_o constant, addresses contiguous.
REQ-042 Reset asserted with count_o = 3, inflight = 1 -> next cycle valid_o = 0, count_o = 0, req_addr_o = RESET_PC.
